// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr_pkg
// Brief   : Shared DDR controller types: address field widths, RAF entry.
// Revision: 1.0  initial release
// ============================================================================
package ddr_pkg;

  localparam int DDR_BANK_W = 2;
  localparam int DDR_ROW_W  = 13;
  localparam int DDR_COL_W  = 8;
  localparam int DDR_ADDR_W = 23;

  typedef struct packed {
    logic                  block;
    logic [DDR_ADDR_W-1:0] addr;
  } raf_entry_t;

  localparam int RAF_ENTRY_W = $bits(raf_entry_t);

  function automatic logic [DDR_ADDR_W-1:0] ddr_make_addr(
    input logic [DDR_BANK_W-1:0] bank,
    input logic [DDR_ROW_W-1:0]  row,
    input logic [DDR_COL_W-1:0]  col
  );
    return {bank, row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : ddr_fifo_mem
// Brief   : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision: 1.0  initial release
// ============================================================================
module ddr_fifo_mem #(
  parameter int ABITS = 4,
  parameter int WIDTH = 24
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ABITS;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents carry no reset; validity is tracked by the owner's level count.
  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ddr_raf.sv
`default_nettype none
// ============================================================================
// Module  : ddr_raf
// Brief   : DDR read-address FIFO, first-word-fall-through head for the
//           scheduler. Optional sticky error flags: DDR_RAF_ERRFLAGS_EN.
// Revision: 1.0  initial release
// ============================================================================
module ddr_raf
  import ddr_pkg::*;
#(
  parameter int ABITS     = 4,
  parameter int AFULL_GAP = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  usr_write_i,
  input  logic                  usr_block_i,
  input  logic [DDR_ADDR_W-1:0] usr_addr_i,
  output logic                  usr_full_o,
  output logic                  usr_afull_o,
  output logic                  raf_empty_no,
  output logic                  raf_one_o,
  output logic                  raf_block_o,
  output logic [DDR_ADDR_W-1:0] raf_addr_o,
  input  logic                  raf_read_i,
  output logic [ABITS:0]        raf_level_o
`ifdef DDR_RAF_ERRFLAGS_EN
  ,
  output logic                  err_ovf_o,
  output logic                  err_udf_o
`endif
);

  localparam int             DEPTH     = 2 ** ABITS;
  localparam logic [ABITS:0] LVL_FULL  = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] LVL_AFULL = (ABITS+1)'(DEPTH - AFULL_GAP);

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   level_q, level_d;
  logic             empty_n_q, empty_n_d;
  logic             one_q, one_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             push_ok, pop_ok;
  raf_entry_t       wr_entry, head_entry;

  assign wr_entry = '{block: usr_block_i, addr: usr_addr_i};

  always_comb begin
    push_ok  = usr_write_i && !full_q;
    // A blocked push while full freezes the whole cycle, the pop included.
    pop_ok   = raf_read_i && empty_n_q && !(usr_write_i && full_q);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ABITS'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ABITS'(1);
    if (push_ok && !pop_ok)      level_d = level_q + (ABITS+1)'(1);
    else if (pop_ok && !push_ok) level_d = level_q - (ABITS+1)'(1);
    empty_n_d = (level_d != '0);
    one_d     = (level_d == (ABITS+1)'(1));
    full_d    = (level_d == LVL_FULL);
    afull_d   = (level_d >= LVL_AFULL);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_n_q <= 1'b0;
      one_q     <= 1'b0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_n_q <= empty_n_d;
      one_q     <= one_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
    end
  end

  ddr_fifo_mem #(
    .ABITS (ABITS),
    .WIDTH (RAF_ENTRY_W)
  ) u_mem (
    .clock_i (clock_i),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // Storage is never cleared, so the head is masked to zero while empty.
  assign raf_addr_o   = empty_n_q ? head_entry.addr  : '0;
  assign raf_block_o  = empty_n_q ? head_entry.block : 1'b0;
  assign raf_empty_no = empty_n_q;
  assign raf_one_o    = one_q;
  assign usr_full_o   = full_q;
  assign usr_afull_o  = afull_q;
  assign raf_level_o  = level_q;

`ifdef DDR_RAF_ERRFLAGS_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q || (usr_write_i && full_q);
    err_udf_d = err_udf_q || (raf_read_i && !empty_n_q);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf_o = err_ovf_q;
  assign err_udf_o = err_udf_q;
`endif

endmodule
`default_nettype wire
